// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg
//   Shared constants and types for the instruction fetch controller:
//   default address width, instruction width, PC increment and the
//   fetch FSM state encoding.
package fetch_controller_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int INSTR_W    = 32;
  localparam int PC_INC     = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // True when the two low byte-address bits select a whole word.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
//   Fetched-instruction stream from fetch toward decode.
//   Signals:
//     if_valid  - head instruction is valid
//     if_pc     - byte address of the head instruction
//     if_instr  - head instruction word
//     id_ready  - decode accepts; transfer when if_valid && id_ready
//   Modports:
//     master - fetch side (drives valid/pc/instr, samples ready)
//     slave  - decode side
interface fetch_controller_if
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic               if_valid;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               id_ready;

  modport master (output if_valid, output if_pc, output if_instr, input id_ready);
  modport slave  (input if_valid, input if_pc, input if_instr, output id_ready);

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small first-word-fall-through FIFO holding fetched {pc, instr} pairs.
//   The head entry is visible combinationally; storage is reset to zero so
//   the head reads as zero out of reset.
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     flush       - discard all entries (wins over push and pop)
//     push        - write push_data at the tail
//     push_data   - entry to write
//     pop         - drop the head entry (ignored when empty)
//     head_data   - current head entry
//     count       - number of valid entries
module fetch_fifo
  import fetch_controller_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ADDR_W_DEF + INSTR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_ptr_q == PTR_W'(i)) begin
            mem_d[i] = push_data;
          end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
//   Instruction fetch front end: steers the external program counter,
//   issues synchronous instruction-memory reads, buffers responses in a
//   FIFO and presents them in order to decode. Redirects flush everything
//   younger and restart fetch at the target.
//   Optional feature (macro FETCH_MISALIGN_CHECK_EN): a redirect to a
//   target with nonzero low bits halts fetch and raises fetch_misalign
//   until the next aligned redirect. Without the macro the low target bits
//   are forced to zero and the port does not exist.
//   Ports:
//     clk, reset       - clock, asynchronous active-high reset
//     current_pc       - registered PC from the program counter
//     next_pc, PCWrite - PC load value and load enable
//     imem_addr        - instruction memory address (1-cycle read latency)
//     imem_rdata       - word for the address issued the previous cycle
//     redirect_valid   - taken branch/jump; flush and refetch
//     redirect_target  - redirect destination
//     dec              - fetched-instruction stream toward decode
//     fetch_misalign   - misaligned redirect seen (optional)
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  current_pc,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               PCWrite,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  fetch_controller_if.master dec
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               fetch_misalign
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  fetch_state_e       state_q, state_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]   fifo_count;
  logic [ENT_W-1:0]   head_data;
  logic               flush, push, pop, pc_write, has_room, redirect_bad;
  logic [SUM_W-1:0]   fill_after_pop;
  logic [ADDR_W-1:0]  target_eff;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_eff   = redirect_target;
  assign redirect_bad = !is_word_aligned(redirect_target[1:0]);
`else
  assign target_eff   = redirect_target & ~ADDR_W'(3);
  assign redirect_bad = 1'b0;
`endif

  assign imem_addr    = current_pc;
  assign dec.if_valid = (fifo_count != '0);
  assign dec.if_pc    = head_data[INSTR_W +: ADDR_W];
  assign dec.if_instr = head_data[INSTR_W-1:0];
  assign pop          = dec.if_valid && dec.id_ready;

  // Space check counts the entry leaving this cycle and the read still in
  // flight, so a full buffer never receives a response it cannot hold.
  assign fill_after_pop = SUM_W'(fifo_count) + SUM_W'(inflight_q) - SUM_W'(pop);
  assign has_room       = (fill_after_pop < SUM_W'(BUF_DEPTH));

  always_comb begin
    state_d       = state_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    pc_write      = 1'b0;
    next_pc       = current_pc + ADDR_W'(PC_INC);
    flush         = 1'b0;
    // A response lands one cycle after issue; a redirect discards it.
    push          = inflight_q && !redirect_valid;
    if (redirect_valid) begin
      flush   = 1'b1;
      next_pc = target_eff;
      if (redirect_bad) begin
        state_d = ST_HALT;
      end else begin
        state_d  = ST_RUN;
        pc_write = 1'b1;
      end
    end else if ((state_q == ST_RUN) && has_room) begin
      pc_write      = 1'b1;
      inflight_d    = 1'b1;
      inflight_pc_d = current_pc;
    end
  end

  // Held off while reset is asserted so the PC stays at its reset value.
  assign PCWrite = pc_write && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misalign = (state_q == ST_HALT);
`endif

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({inflight_pc_q, imem_rdata}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
//   Directed and random stimulus for fetch_controller with a queue-based
//   reference model of the fetch buffer and an in-order stream scoreboard.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] current_pc, next_pc, imem_addr, redirect_target;
  logic          PCWrite, redirect_valid;
  logic [31:0]   imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          fetch_misalign;
`endif

  always #5 clk = ~clk;

  fetch_controller_if #(.ADDR_W(AW)) dif ();

  fetch_controller #(.ADDR_W(AW), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .current_pc      (current_pc),
    .next_pc         (next_pc),
    .PCWrite         (PCWrite),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec             (dif.master)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [AW-1:0] pc);
    return 32'hC0DE_0000 | 32'(pc);
  endfunction

  // Environment: program counter register and synchronous instruction memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) current_pc <= '0;
    else if (PCWrite) current_pc <= next_pc;
  end

  always_ff @(posedge clk) imem_rdata <= instr_of(imem_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [AW-1:0] m_q[$];
  bit            m_inflight;
  logic [AW-1:0] m_inflight_pc;
  logic [AW-1:0] m_pc;
  bit            m_halt;
  logic [AW-1:0] s_pc;

  // Observations from the latest step.
  bit            o_valid, o_pcw, o_mis;
  logic [AW-1:0] o_pc, o_cur, o_next;

  function automatic bit misaligned(input logic [AW-1:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [AW-1:0] eff(input logic [AW-1:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return {t[AW-1:2], 2'b00};
`endif
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    dif.id_ready = 1'b0;
    #1;
    chk("rst_PCWrite", 64'(PCWrite), 64'(0));
    chk("rst_if_valid", 64'(dif.if_valid), 64'(0));
    chk("rst_if_pc", 64'(dif.if_pc), 64'(0));
    chk("rst_if_instr", 64'(dif.if_instr), 64'(0));
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    m_q.delete();
    m_inflight = 1'b0;
    m_pc = '0;
    m_halt = 1'b0;
    s_pc = '0;
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [AW-1:0] rt);
    bit            pop, room, exp_pcw;
    logic [AW-1:0] exp_next;
    dif.id_ready    = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    @(negedge clk);
    pop  = (m_q.size() > 0) && rdy;
    room = (m_q.size() + int'(m_inflight) - int'(pop)) < DEPTH;
    if (rv) begin
      exp_pcw  = !misaligned(rt);
      exp_next = eff(rt);
    end else begin
      exp_pcw  = !m_halt && room;
      exp_next = m_pc + AW'(4);
    end
    chk("current_pc", 64'(current_pc), 64'(m_pc));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("PCWrite", 64'(PCWrite), 64'(exp_pcw));
    if (exp_pcw || !rv) chk("next_pc", 64'(next_pc), 64'(exp_next));
    chk("if_valid", 64'(dif.if_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("if_pc", 64'(dif.if_pc), 64'(m_q[0]));
      chk("if_instr", 64'(dif.if_instr), 64'(instr_of(m_q[0])));
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_misalign", 64'(fetch_misalign), 64'(m_halt));
    o_mis = fetch_misalign;
`endif
    if (dif.if_valid && rdy) begin
      chk("stream_order", 64'(dif.if_pc), 64'(s_pc));
      s_pc = s_pc + AW'(4);
    end
    o_valid = dif.if_valid;
    o_pc    = dif.if_pc;
    o_pcw   = PCWrite;
    o_cur   = current_pc;
    o_next  = next_pc;
    $display("t=%0t rdy=%0d rv=%0d rt=%03h pc=%03h pcw=%0d nxt=%03h if_v=%0d if_pc=%03h",
             $time, rdy, rv, rt, current_pc, PCWrite, next_pc, dif.if_valid, dif.if_pc);
    @(posedge clk);
    #1;
    if (rv) begin
      m_q.delete();
      m_inflight = 1'b0;
      if (!misaligned(rt)) begin
        m_pc   = eff(rt);
        m_halt = 1'b0;
        s_pc   = eff(rt);
      end else begin
        m_halt = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_pc);
      m_inflight = 1'b0;
      if (exp_pcw) begin
        m_inflight    = 1'b1;
        m_inflight_pc = m_pc;
        m_pc          = m_pc + AW'(4);
      end
    end
  endtask

  initial begin
    logic [AW-1:0] rt;
    bit            rdy, rv;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    dif.id_ready    = 1'b0;
    do_reset(3);

    // Streaming from reset: first instruction at cycle 2, one per cycle.
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, '0);
      if (c < 2) chk("no_bypass", 64'(o_valid), 64'(0));
      else if (c <= 4) chk("stream_from_reset", 64'({o_valid, o_pc}), 64'({1'b1, AW'(4 * (c - 2))}));
    end

    // Decode stall: buffer fills, PC freezes, then drains in order.
    do_reset(1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0);
    chk("stall_PCWrite", 64'(o_pcw), 64'(0));
    chk("stall_pc_frozen", 64'(o_cur), 64'(10'h008));
    step(1'b1, 1'b0, '0);
    chk("drain_first", 64'({o_valid, o_pc}), 64'({1'b1, 10'h000}));
    step(1'b1, 1'b0, '0);
    chk("drain_second", 64'({o_valid, o_pc}), 64'({1'b1, 10'h004}));

    // Redirect while a response is in flight and the head is popped.
    do_reset(1);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 10'h100);
    chk("redirect_pop_valid", 64'(o_valid), 64'(1));
    step(1'b1, 1'b0, '0);
    chk("redir_t1_empty", 64'(o_valid), 64'(0));
    step(1'b1, 1'b0, '0);
    chk("redir_t2_empty", 64'(o_valid), 64'(0));
    step(1'b1, 1'b0, '0);
    chk("redir_t3_target", 64'({o_valid, o_pc}), 64'({1'b1, 10'h100}));

    // Back-to-back redirects: the last one wins.
    step(1'b1, 1'b1, 10'h200);
    step(1'b1, 1'b1, 10'h300);
    step(1'b1, 1'b0, '0);
    chk("b2b_t1_empty", 64'(o_valid), 64'(0));
    step(1'b1, 1'b0, '0);
    chk("b2b_t2_empty", 64'(o_valid), 64'(0));
    step(1'b1, 1'b0, '0);
    chk("b2b_t3_target", 64'({o_valid, o_pc}), 64'({1'b1, 10'h300}));

    // Address wrap at the top of the instruction space.
    step(1'b1, 1'b1, 10'h3F8);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("wrap_cur", 64'(o_cur), 64'(10'h3FC));
    chk("wrap_next_pc", 64'(o_next), 64'(10'h000));
    chk("wrap_PCWrite", 64'(o_pcw), 64'(1));
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, '0);

    // Reset pulse in the middle of a stream.
    do_reset(1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, '0);
      if (c == 2) chk("post_reset_first", 64'({o_valid, o_pc}), 64'({1'b1, 10'h000}));
    end

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rt  = AW'($urandom);
`ifdef FETCH_MISALIGN_CHECK_EN
      rt  = rt & ~AW'(3);
`endif
      if ($urandom_range(0, 199) == 0) do_reset(1);
      step(rdy, rv, rt);
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch until an aligned redirect.
    step(1'b1, 1'b1, 10'h102);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, '0);
      chk("misalign_flag", 64'(o_mis), 64'(1));
      chk("misalign_no_issue", 64'(o_pcw), 64'(0));
    end
    step(1'b1, 1'b1, 10'h200);
    step(1'b1, 1'b0, '0);
    chk("misalign_cleared", 64'(o_mis), 64'(0));
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("misalign_recover", 64'({o_valid, o_pc}), 64'({1'b1, 10'h200}));
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of the instruction space.
REQ-002 Parameter BUF_DEPTH, default 2, fetch buffer entries (power of two, ≥2).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 current_pc  input  ADDR_W  registered PC value from the program counter.
REQ-006 next_pc  output  ADDR_W  value the program counter loads when PCWrite=1.
REQ-007 PCWrite  output  1  program counter load enable.
REQ-008 imem_addr  output  ADDR_W  instruction memory address (synchronous read, 1-cycle latency).
REQ-009 imem_rdata  input  32  instruction word for the address issued the previous cycle.
REQ-010 redirect_valid  input  1  branch/jump resolved taken; flush and refetch.
REQ-011 redirect_target  input  ADDR_W  redirect destination.
REQ-012 if_valid / if_pc / if_instr  output  1/ADDR_W/32  fetched-instruction stream toward decode.
REQ-013 id_ready  input  1  decode accepts; transfer when if_valid && id_ready.

Function
REQ-014 imem_addr SHALL equal current_pc combinationally.
REQ-015 Issue SHALL occur in a cycle when occupancy + in-flight − pop < BUF_DEPTH, state is RUN, and redirect_valid=0; issue drives PCWrite=1, next_pc=current_pc+4 (mod 2^ADDR_W, wrap 0x3FC→0x000).
REQ-016 Issued fetch in cycle N: in-flight flag set, pc captured; imem_rdata written into buffer at end of N+1; if_valid for that entry no earlier than N+2 (no bypass).
REQ-017 Buffer SHALL be FIFO ordered; if_pc/if_instr present the head entry; pop on if_valid && id_ready.
REQ-018 Full buffer (no issue possible): PCWrite=0, current_pc held, no instruction lost or duplicated.
REQ-019 redirect_valid in cycle T: PCWrite=1, next_pc=redirect_target, buffer flushed, in-flight response arriving T+1 discarded, if_valid=0 at T+1; target instruction presented at T+3.
REQ-020 Redirect simultaneous with pop or with a returning response: redirect wins; popped entry counts as consumed, response discarded.
REQ-021 Back-to-back redirects: last one wins; each restarts the T+3 latency.
REQ-022 Streaming with id_ready held 1 and BUF_DEPTH≥2: one instruction per cycle sustained.
REQ-023 FSM states: RUN (normal), HALT (only under REQ-028); RUN→HALT per REQ-028; HALT→RUN only on a subsequent aligned redirect.

Reset
REQ-024 While reset=1: PCWrite=0, if_valid=0, buffer empty, in-flight cleared, state RUN.
REQ-025 Reset asserted mid-fetch SHALL drop all buffered and in-flight instructions; first issue from current_pc (0) in the first cycle after reset deasserts.
REQ-026 if_pc/if_instr SHALL reset to 0; next_pc SHALL equal current_pc+4 when not redirecting.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN selects the alignment check.
REQ-028 Defined: redirect with redirect_target[1:0]≠0 flushes, sets PCWrite=0, enters HALT (no issue), asserts output fetch_misalign (1 bit) until next aligned redirect; undefined: port absent, target bits [1:0] forced to 0, state stays RUN.

Structure
REQ-029 Shared package holds ADDR_W default, instruction width 32, PC increment 4, FSM state encoding.
REQ-030 Buffer SHALL be sub-module fetch_fifo (synchronous, flush input, count output); controller holds FSM and in-flight tracking.

Verification
REQ-031 Reset, id_ready=1, imem returns pc-as-data -> if_pc 0x000,0x004,0x008 on consecutive cycles from cycle 2.
REQ-032 id_ready=0 for 6 cycles -> exactly BUF_DEPTH entries buffered, PCWrite=0, current_pc frozen at 0x008; release -> 0x000,0x004 delivered in order.
REQ-033 Redirect to 0x100 while fetching 0x010 -> 0x014 response dropped, next if_pc=0x100 three cycles later.
REQ-034 current_pc=0x3FC -> next_pc=0x000, streaming continues.
REQ-035 Redirect coincident with pop and with reset pulse mid-stream -> no duplicate/stale if_pc; after reset first if_pc=0x000.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misalign=1, PCWrite=0; redirect to 0x200 -> RUN, if_pc=0x200.
